nic_host_ctrl: RTL and testbench
================================

# nic_host_ctrl

Sequencer that drives one NIC's processor-side register port on behalf of a simple host. It shares that single port between an outbound (tx) request stream and inbound (rx) polling. It polls the NIC status registers, writes outbound packets when the output channel has room, and reads inbound packets when the input channel is full. One instance sits between each node's host logic and its NIC inside the four-node cardinal NIC cluster.

## Interface
- CNT_W, 16, width of the tx/rx packet counters
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- tx_valid  in  1  host has an outbound packet on tx_data
- tx_data  in  [0:63]  outbound packet; held stable while tx_valid=1
- tx_ready  out  1  packet accepted this cycle (written to the NIC)
- rx_valid  out  1  rx_data holds an inbound packet
- rx_data  out  [0:63]  inbound packet, registered
- rx_ready  in  1  host consumes rx_data this cycle when rx_valid=1
- nic_addr  out  [0:1]  NIC register select
- nic_d_in  out  [0:63]  write data to the NIC
- nic_d_out  in  [0:63]  read data from the NIC
- nic_en  out  1  NIC access strobe
- nic_wr_en  out  1  NIC write strobe; qualified by nic_en
- tx_count  out  [CNT_W-1:0]  packets written to the NIC, wraps
- rx_count  out  [CNT_W-1:0]  packets read from the NIC, wraps

## Operation
- NIC register map:
  - 2'b00: input buffer (read).
  - 2'b01: input status (read; nic_d_out[63]=1 means a packet is present).
  - 2'b10: output buffer (write).
  - 2'b11: output status (read; nic_d_out[63]=1 means the channel is full).
- NIC access rules:
  - A read is nic_en=1, nic_wr_en=0. Its data is valid on nic_d_out in the following cycle.
  - A write is nic_en=1, nic_wr_en=1. It commits at the clock edge.
- Candidates each time the FSM is in IDLE:
  - TX is a candidate when tx_valid=1.
  - RX is a candidate when rx_valid=0.
  - If both are candidates, the one not in `last` wins. `last` is a 1-bit register; its reset value is "rx", so TX wins the first conflict.
  - If there are no candidates, the FSM stays in IDLE.
- FSM states:
  - IDLE: decide the next path per the candidate rules.
  - TX_STAT: read addr 11.
  - TX_CHK: if nic_d_out[63]=1, go to IDLE and set last=tx. Otherwise go to TX_WR.
  - TX_WR: drive addr 10, nic_wr_en=1, nic_d_in=tx_data, tx_ready=1. Increment tx_count. Go to IDLE and set last=tx.
  - RX_STAT: read addr 01.
  - RX_CHK: if nic_d_out[63]=0, go to IDLE and set last=rx. Otherwise go to RX_RD.
  - RX_RD: read addr 00.
  - RX_CAP: at the edge, rx_data<=nic_d_out, rx_valid<=1, increment rx_count. Go to IDLE and set last=rx.
- Output decoding outside the active states:
  - nic_en, nic_wr_en and tx_ready are decoded from the state and are 0 in all other states.
  - nic_addr is 2'b00 and nic_d_in is 0 when not driven.
- rx hold: rx_valid stays at 1 and rx_data stays stable until a cycle with rx_valid=1 and rx_ready=1. rx_valid clears at that edge. No new RX poll starts while rx_valid=1.
- A tx_valid drop before TX_WR is not permitted. If the drop coincides with TX_CHK, the FSM still returns through TX_WR only if tx_valid=1 in TX_WR. Otherwise the FSM goes to IDLE without writing and without counting.
- Counters wrap from 2^CNT_W-1 to 0.

## Timing
- Reset:
  - Next state IDLE, last=rx, rx_valid=0, rx_data=0, both counters 0.
  - nic_en, nic_wr_en and tx_ready are gated by !reset. No NIC access occurs in a reset cycle, even mid-operation.
  - A packet in flight is abandoned. Its tx_data is re-sent after reset if tx_valid is still 1.
- TX best case, with tx_valid rising in cycle 0 while in IDLE with priority:
  - Status read in cycle 1 (TX_STAT).
  - Check in cycle 2 (TX_CHK).
  - Write and tx_ready=1 in cycle 3 (TX_WR).
  - tx_count updates at the end of cycle 3.
- TX when the output channel is full: the TX attempt takes 3 cycles (IDLE, TX_STAT, TX_CHK) and returns to IDLE. RX gets the next turn if it is a candidate. Otherwise TX retries immediately.
- RX best case, with the decision in cycle 0:
  - RX_STAT in cycle 1, RX_CHK in cycle 2, RX_RD in cycle 3, RX_CAP in cycle 4.
  - rx_valid=1 from cycle 5.
- The throughput bound is one NIC access per cycle, with at most one outstanding transaction.

## Test plan
- Reset while in TX_WR with tx_data=64'hA5 -> no write observed, FSM in IDLE next cycle, counters 0, rx_valid=0, and the packet is rewritten later exactly once.
- Output status empty, tx_valid=1, tx_data=64'h0123_4567_89AB_CDEF, rx status empty -> write to addr 10 with that data in cycle 3, tx_ready=1 for exactly one cycle, tx_count=1.
- Input status full, input buffer 64'hDEAD_BEEF_0000_0001, rx_ready=0 -> rx_valid=1 from cycle 5 and rx_data equals that value. No further addr 01 reads until rx_ready=1 is applied. rx_count=1.
- tx_valid=1 and input always full, host always rx_ready=1 -> accesses alternate TX then RX, starting with TX after reset, and counts stay within 1 of each other.
- Output status full for 10 polls, then empty -> no tx_ready during the full period, a single write afterwards, tx_count=1.
- Preload tx_count to 2^CNT_W-1 via 65535 writes with CNT_W=16, then one more write -> tx_count=0.

Source files
------------

// File: rtl/nic_host_ctrl.sv
// nic_host_ctrl: drives one NIC register port for a host. Outbound packet writes
// share the port with inbound status polling; contention alternates via `last`.
module nic_host_ctrl #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [0:DATA_W-1] tx_data,
  output logic              tx_ready,
  output logic              rx_valid,
  output logic [0:DATA_W-1] rx_data,
  input  logic              rx_ready,
  output logic [0:1]        nic_addr,
  output logic [0:DATA_W-1] nic_d_in,
  input  logic [0:DATA_W-1] nic_d_out,
  output logic              nic_en,
  output logic              nic_wr_en,
  output logic [CNT_W-1:0]  tx_count,
  output logic [CNT_W-1:0]  rx_count
);

  localparam logic [0:1] A_IN_BUF   = 2'b00;
  localparam logic [0:1] A_IN_STAT  = 2'b01;
  localparam logic [0:1] A_OUT_BUF  = 2'b10;
  localparam logic [0:1] A_OUT_STAT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_TX_STAT, S_TX_CHK, S_TX_WR,
    S_RX_STAT, S_RX_CHK, S_RX_RD, S_RX_CAP
  } state_t;

  state_t     state, state_nxt;
  logic       last_tx, last_tx_nxt;
  logic       acc_en, acc_wr, tx_fire, rx_cap;
  logic [0:1] acc_addr;
  logic       stat_bit;

  // Status registers report their flag in the last bit of the word.
  assign stat_bit = nic_d_out[DATA_W-1];

  always_comb begin
    state_nxt   = state;
    last_tx_nxt = last_tx;
    acc_en      = 1'b0;
    acc_wr      = 1'b0;
    acc_addr    = A_IN_BUF;
    tx_fire     = 1'b0;
    rx_cap      = 1'b0;
    case (state)
      S_IDLE: begin
        // TX wins unless RX also wants the port and TX had the previous turn.
        if (tx_valid && (rx_valid || !last_tx)) state_nxt = S_TX_STAT;
        else if (!rx_valid)                     state_nxt = S_RX_STAT;
      end
      S_TX_STAT: begin
        acc_en    = 1'b1;
        acc_addr  = A_OUT_STAT;
        state_nxt = S_TX_CHK;
      end
      S_TX_CHK: begin
        if (stat_bit) begin
          state_nxt   = S_IDLE;
          last_tx_nxt = 1'b1;
        end else begin
          state_nxt = S_TX_WR;
        end
      end
      S_TX_WR: begin
        if (tx_valid) begin
          acc_en   = 1'b1;
          acc_wr   = 1'b1;
          acc_addr = A_OUT_BUF;
          tx_fire  = 1'b1;
        end
        state_nxt   = S_IDLE;
        last_tx_nxt = 1'b1;
      end
      S_RX_STAT: begin
        acc_en    = 1'b1;
        acc_addr  = A_IN_STAT;
        state_nxt = S_RX_CHK;
      end
      S_RX_CHK: begin
        if (!stat_bit) begin
          state_nxt   = S_IDLE;
          last_tx_nxt = 1'b0;
        end else begin
          state_nxt = S_RX_RD;
        end
      end
      S_RX_RD: begin
        acc_en    = 1'b1;
        acc_addr  = A_IN_BUF;
        state_nxt = S_RX_CAP;
      end
      S_RX_CAP: begin
        rx_cap      = 1'b1;
        state_nxt   = S_IDLE;
        last_tx_nxt = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reset suppresses any NIC access, even one already in progress.
  assign nic_en    = acc_en & ~reset;
  assign nic_wr_en = acc_wr & ~reset;
  assign tx_ready  = tx_fire & ~reset;
  assign nic_addr  = reset ? A_IN_BUF : acc_addr;
  assign nic_d_in  = tx_ready ? tx_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      last_tx  <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      tx_count <= '0;
      rx_count <= '0;
    end else begin
      state   <= state_nxt;
      last_tx <= last_tx_nxt;
      if (tx_fire) tx_count <= tx_count + 1'b1;
      if (rx_cap) begin
        rx_data  <= nic_d_out;
        rx_valid <= 1'b1;
        rx_count <= rx_count + 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nic_host_ctrl.sv
// Bench for nic_host_ctrl: a register-level NIC model plus a transaction-level
// scoreboard checked every cycle, and directed scenarios with literal timing.
module tb_nic_host_ctrl;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [0:63]      tx_data, rx_data, nic_d_in, nic_d_out;
  logic [0:1]       nic_addr;
  logic             nic_en, nic_wr_en;
  logic [CNT_W-1:0] tx_count, rx_count;

  always #5 clk = ~clk;

  nic_host_ctrl #(.CNT_W(CNT_W), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .nic_addr(nic_addr), .nic_d_in(nic_d_in),
    .nic_d_out(nic_d_out), .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .tx_count(tx_count), .rx_count(rx_count)
  );

  int checks = 0;
  int passes = 0;

  function void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endfunction

  // NIC model: reads return data one cycle later; output status reports
  // full while out_stat_reads < out_full_until.
  logic        in_full;
  logic [0:63] in_buf;
  int          out_full_until;
  int          out_stat_reads = 0;
  logic        last_out_resp = 1'b0;

  always @(posedge clk) begin
    if (nic_en && !nic_wr_en) begin
      case (nic_addr)
        2'b00: nic_d_out <= in_buf;
        2'b01: nic_d_out <= {63'b0, in_full};
        2'b11: begin
          nic_d_out      <= {63'b0, (out_stat_reads < out_full_until)};
          last_out_resp  <= (out_stat_reads < out_full_until);
          out_stat_reads <= out_stat_reads + 1;
        end
        default: nic_d_out <= '0;
      endcase
    end else begin
      nic_d_out <= {$urandom, $urandom};
    end
  end

  // Scoreboard: expected counters and rx holding register, plus bus protocol.
  int               exp_tx = 0, exp_rx = 0;
  logic             exp_rxv = 1'b0, cap_pend = 1'b0, prev_rd3 = 1'b0, started = 1'b0;
  logic [0:63]      exp_rxd = '0, cap_val = '0;
  int               wr_total = 0, rd1_total = 0;
  int               seq[$];
  logic             diff_chk_en;
  logic [CNT_W-1:0] cnt_diff;

  always @(negedge clk) begin
    if (started) begin
      chk("tx_count", tx_count, exp_tx[CNT_W-1:0]);
      chk("rx_count", rx_count, exp_rx[CNT_W-1:0]);
      chk("rx_valid", rx_valid, exp_rxv);
      chk("rx_data", rx_data, exp_rxd);
      chk("tx_ready_is_write", tx_ready, nic_en && nic_wr_en);
      if (reset) chk("no_access_in_reset", nic_en, 1'b0);
      if (!nic_en) begin
        chk("idle_addr", nic_addr, 2'b00);
        chk("idle_d_in", nic_d_in, 64'h0);
      end
      if (nic_en && nic_wr_en) begin
        chk("wr_addr", nic_addr, 2'b10);
        chk("wr_data", nic_d_in, tx_data);
        chk("wr_tx_valid", tx_valid, 1'b1);
        chk("wr_after_free_status", prev_rd3 && !last_out_resp, 1'b1);
        wr_total++;
        seq.push_back(1);
      end
      if (nic_en && !nic_wr_en && nic_addr == 2'b01) begin
        chk("no_poll_while_rx_valid", exp_rxv, 1'b0);
        rd1_total++;
      end
      if (nic_en && !nic_wr_en && nic_addr == 2'b00) seq.push_back(2);
      if (diff_chk_en) begin
        cnt_diff = tx_count - rx_count;
        chk("count_diff_le1", cnt_diff <= 1, 1'b1);
      end
    end
    if (reset) begin
      exp_tx = 0; exp_rx = 0; exp_rxv = 1'b0; exp_rxd = '0;
      cap_pend = 1'b0; prev_rd3 = 1'b0; started = 1'b1;
    end else if (started) begin
      if (nic_en && nic_wr_en) exp_tx++;
      if (cap_pend) begin
        exp_rxv = 1'b1; exp_rxd = cap_val; exp_rx++; cap_pend = 1'b0;
      end else if (exp_rxv && rx_ready) begin
        exp_rxv = 1'b0;
      end
      if (nic_en && !nic_wr_en && nic_addr == 2'b00) begin
        cap_pend = 1'b1; cap_val = in_buf;
      end
      if (nic_en) prev_rd3 = !nic_wr_en && nic_addr == 2'b11;
    end
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task wait_tx_ready(input int max, input string name);
    int n;
    n = 0;
    while (!tx_ready && n < max) begin
      tick();
      n++;
    end
    chk(name, tx_ready, 1'b1);
  endtask

  int w, rd1, s0, nops, exp_reads;

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    in_full = 1'b0; in_buf = '0; out_full_until = 0; diff_chk_en = 1'b0;
    repeat (3) tick();
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_nic_en", nic_en, 0);

    // TX best case straight out of reset (TX wins the first conflict).
    reset = 1'b0; tx_valid = 1'b1; tx_data = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("c0_no_access", nic_en, 0);
    tick();
    chk("c1_stat_en", nic_en, 1);
    chk("c1_stat_addr", nic_addr, 2'b11);
    chk("c1_stat_rd", nic_wr_en, 0);
    tick();
    chk("c2_no_access", nic_en, 0);
    chk("c2_tx_ready", tx_ready, 0);
    tick();
    chk("c3_tx_ready", tx_ready, 1);
    chk("c3_wr_en", nic_wr_en, 1);
    chk("c3_addr", nic_addr, 2'b10);
    chk("c3_d_in", nic_d_in, 64'h0123_4567_89AB_CDEF);
    tick();
    tx_valid = 1'b0; in_full = 1'b1; in_buf = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("c4_tx_ready_low", tx_ready, 0);
    chk("c4_tx_count", tx_count, 1);

    // RX best case: decision in cycle 4, rx_valid from cycle 9.
    tick();
    chk("rx_stat_en", nic_en, 1);
    chk("rx_stat_addr", nic_addr, 2'b01);
    tick();
    tick();
    chk("rx_rd_en", nic_en, 1);
    chk("rx_rd_addr", nic_addr, 2'b00);
    tick();
    chk("rx_cap_not_yet", rx_valid, 0);
    tick();
    chk("rx_valid_set", rx_valid, 1);
    chk("rx_data_val", rx_data, 64'hDEAD_BEEF_0000_0001);
    chk("rx_count_1", rx_count, 1);
    rd1 = rd1_total;
    repeat (12) tick();
    chk("no_poll_while_held", rd1_total - rd1, 0);
    chk("rx_data_held", rx_data, 64'hDEAD_BEEF_0000_0001);
    rx_ready = 1'b1; in_full = 1'b0;
    tick();
    chk("rx_valid_cleared", rx_valid, 0);
    rd1 = rd1_total;
    repeat (6) tick();
    chk("poll_resumes", rd1_total > rd1, 1);

    // Reset landing in TX_WR: no write, packet resent exactly once.
    do_reset(2);
    tx_valid = 1'b1; tx_data = 64'hA5;
    repeat (3) tick();
    chk("a5_pre_reset_wr", tx_ready, 1);
    reset = 1'b1;
    w = wr_total;
    #1;
    chk("a5_rst_no_en", nic_en, 0);
    chk("a5_rst_no_ready", tx_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("a5_idle_no_access", nic_en, 0);
    chk("a5_tx_count_0", tx_count, 0);
    chk("a5_rx_count_0", rx_count, 0);
    chk("a5_rx_valid_0", rx_valid, 0);
    tick();
    chk("a5_restat_addr", nic_addr, 2'b11);
    chk("a5_restat_en", nic_en, 1);
    wait_tx_ready(20, "a5_rewrite_seen");
    chk("a5_rewrite_data", nic_d_in, 64'hA5);
    tick();
    tx_valid = 1'b0;
    repeat (8) tick();
    chk("a5_written_once", wr_total - w, 1);
    chk("a5_tx_count_1", tx_count, 1);

    // Output channel full for 10 polls, then free.
    out_full_until = out_stat_reads + 10;
    exp_reads = out_full_until + 1;
    do_reset(2);
    tx_valid = 1'b1; tx_data = 64'h5555_AAAA_1234_0F0F;
    w = wr_total;
    wait_tx_ready(300, "full_then_write");
    chk("full_status_reads", out_stat_reads, exp_reads);
    chk("no_write_while_full", wr_total - w, 0);
    chk("full_wr_data", nic_d_in, 64'h5555_AAAA_1234_0F0F);
    tick();
    tx_valid = 1'b0;
    repeat (5) tick();
    chk("full_single_write", wr_total - w, 1);
    chk("full_tx_count_1", tx_count, 1);

    // Both sides always busy: strict TX/RX alternation starting with TX.
    do_reset(2);
    in_full = 1'b1; in_buf = 64'h1111_2222_3333_4444; rx_ready = 1'b1;
    tx_valid = 1'b1; tx_data = 64'hFEED_0000_0000_0001;
    s0 = seq.size();
    diff_chk_en = 1'b1;
    repeat (80) tick();
    diff_chk_en = 1'b0;
    nops = seq.size() - s0;
    chk("alt_enough_ops", nops >= 8, 1);
    for (int i = 0; i < 8; i++) chk("alt_order", seq[s0 + i], (i % 2 == 0) ? 1 : 2);

    // Counter wrap: 2^CNT_W-1 writes, then one more.
    tx_valid = 1'b0; in_full = 1'b0;
    do_reset(2);
    tx_valid = 1'b1;
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      tx_data = 64'hC0DE_0000_0000_0000 + 64'(i);
      wait_tx_ready(20, "wrap_wr");
      tick();
    end
    chk("tx_count_all_ones", tx_count, (1 << CNT_W) - 1);
    tx_data = 64'hC0DE_FFFF_FFFF_FFFF;
    wait_tx_ready(20, "wrap_last_wr");
    tick();
    chk("tx_count_wrapped", tx_count, 0);
    tx_valid = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
